// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter
// Two-master, one-slave Avalon-MM arbiter. One master owns the slave bus for
// exactly one complete transfer; the other master is stalled with waitrequest.
// After each transfer the FSM returns to IDLE for one cycle and re-arbitrates.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on a tie in IDLE the master that did not own the bus last wins
//   undefined : fixed priority, m0 always wins a tie
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   m0_* / m1_*                master-side Avalon-MM ports (address, read, write,
//                              writedata, byteenable in; waitrequest, readdata out)
//   s_*                        slave-side Avalon-MM port
//   grant                      one-hot current owner {m1, m0}, 2'b00 when idle
module avalon_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,

    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    logic   last;       // most recent owner: 0 = m0, 1 = m1
    logic   m0_req;
    logic   m1_req;
    logic   pick_m1;    // arbitration result used when leaving IDLE

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the master that was not last served wins.
    assign pick_m1 = m1_req & (~m0_req | ~last);
`else
    // Fixed priority; last is kept up to date but does not steer the choice.
    assign pick_m1 = m1_req & ~m0_req;
    logic unused_last;
    assign unused_last = last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        if (pick_m1) begin
                            state <= OWN1;
                            grant <= 2'b10;
                        end else begin
                            state <= OWN0;
                            grant <= 2'b01;
                        end
                    end
                end
                OWN0: begin
                    // Completion or a dropped request both release the bus.
                    if (!m0_req || !s_waitrequest) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_req || !s_waitrequest) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        last  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Slave-side mux and master stalls. A granted master that has dropped its
    // request gets an all-zero slave cycle so nothing spurious reaches the slave.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            OWN0: begin
                m0_waitrequest = s_waitrequest;
                if (m0_req) begin
                    s_address    = m0_address;
                    s_read       = m0_read;
                    s_write      = m0_write;
                    s_writedata  = m0_writedata;
                    s_byteenable = m0_byteenable;
                end
            end
            OWN1: begin
                m1_waitrequest = s_waitrequest;
                if (m1_req) begin
                    s_address    = m1_address;
                    s_read       = m1_read;
                    s_write      = m1_write;
                    s_writedata  = m1_writedata;
                    s_byteenable = m1_byteenable;
                end
            end
            default: ;
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: doc/avalon_bus_arbiter.md
# avalon_bus_arbiter

Two-master, one-slave Avalon-MM arbiter that shares the single memory bus between the CPU core (`mips_cpu_bus` master port) and a second requester such as a program loader, DMA or debug port. It grants one master at a time, forwards that master's transfer to the slave unchanged, and stalls the other master with `waitrequest`. Grant is held for exactly one complete transfer, then re-arbitrated.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `m0_address`, `m1_address`  in  ADDR_W  master addresses
- `m0_read`, `m1_read`  in  1  read request
- `m0_write`, `m1_write`  in  1  write request
- `m0_writedata`, `m1_writedata`  in  DATA_W  write data
- `m0_byteenable`, `m1_byteenable`  in  DATA_W/8  lane enables
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to master
- `m0_readdata`, `m1_readdata`  out  DATA_W  read data to master
- `s_address`  out  ADDR_W  to slave
- `s_read`, `s_write`  out  1  to slave
- `s_writedata`  out  DATA_W  to slave
- `s_byteenable`  out  DATA_W/8  to slave
- `s_waitrequest`  in  1  slave stall
- `s_readdata`  in  DATA_W  slave read data
- `grant`  out  2  one-hot current owner, `2'b00` when idle

## Operation
- Request: `mN_req = mN_read | mN_write`.
- FSM states `IDLE`, `OWN0`, `OWN1`; `grant` = {state==OWN1, state==OWN0}.
- `IDLE`: no slave request driven (`s_read=s_write=0`, `s_byteenable=0`, address/data zero). Arbitrate among the masters requesting this cycle and go to `OWNx` on the next edge. No request: stay `IDLE`.
- `OWNx`: `s_*` = master x's `address/read/write/writedata/byteenable` combinationally; `mx_waitrequest = s_waitrequest`.
- Transfer completes in the cycle `OWNx` with `mx_req=1` and `s_waitrequest=0`; next state is `IDLE`. The grant is never transferred directly from one owner to the other.
- `OWNx` with `mx_req=0`, a protocol violation by the master: go to `IDLE` next edge, no slave request driven that cycle.
- Non-owner master: `waitrequest=1` whenever it requests, including in `IDLE`. Non-requesting master: `waitrequest=1` (don't-care).
- `m0_readdata = m1_readdata = s_readdata`, broadcast. Valid only to the owner in its completion cycle.
- The `last` register records the most recent owner. It updates on the transition `OWNx`->`IDLE` and resets to 1, so m0 is favoured first.
- Arbitration when both masters request: see Configuration.
- Byteenable, address and data pass through unmodified. No endianness conversion happens here.

## Timing
- Reset values: state `IDLE`, `last=1`, `grant=0`, `s_read=s_write=0`, `s_byteenable=0`, both `waitrequest=1`.
- Reset asserted mid-transfer: state goes to `IDLE` on that edge and the slave request drops the next cycle. The slave must tolerate the abort.
- Arbitration latency: a request first seen at edge N in `IDLE` is driven to the slave in cycle N+1.
- Minimum cost per transfer: 2 cycles (1 arbitration + 1 transfer with `s_waitrequest=0`). Each slave wait cycle adds 1.
- Back-to-back requests from one master with the other idle: transfers are 2 cycles apart because of the mandatory `IDLE` cycle.
- The CPU fetch loop sees `waitrequest=1` in its first `STATE_FETCH` cycle. This is legal, and the core's `waitrequest_prev` logic handles it.
- No combinational path from `mN_*` to `mN_waitrequest` except through `s_waitrequest` in `OWNx`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both masters request in `IDLE`, grant goes to the master that is not `last`. Requests are served strictly alternately under contention.
- Undefined: fixed priority, m0 always wins a tie. `last` is still maintained but ignored. m1 can starve.

## Test plan
- Single master: m0 read 0xBFC00000, slave `waitrequest=0`, `readdata=0x8C020004`. Expect grant=01 one cycle after request, `m0_readdata=0x8C020004` with `m0_waitrequest=0` in cycle 2, then `IDLE`.
- Slave stall: m1 write 0x1000 data 0xDEADBEEF be=0xF, `s_waitrequest` high 3 cycles. Expect `s_write` held 4 cycles with stable address/data, `m1_waitrequest` mirrors the slave, m0 is not granted meanwhile.
- Contention: both masters request continuously, 4 transfers each. RR build: grant order 0,1,0,1…. Non-RR build: m0 every transfer, m1 `waitrequest` stays 1.
- Simultaneous arrival after reset (RR): expect m0 is granted first (`last=1`).
- Reset mid-transfer: assert reset while OWN1 is stalled by the slave. Expect `grant=0`, `s_read=s_write=0` next cycle, both `waitrequest=1`.
- Master drops request in OWN0: expect return to `IDLE` next edge, no spurious slave access, m1 granted afterwards.
